axi_req_queue: RTL

- Upstream stage of simple_axi_master: accepts load/store requests from the core over a valid/ready port and buffers them in a small FIFO.
- Issues requests one at a time on the master's i_rw/i_addr/i_wdata/i_wsize bus and collects done/error/rdata.
- Performs the done/clear_done handshake and returns tagged responses in order.
- Rejects misaligned or bad-size requests locally; these never reach AXI.

---
 rtl/axi_req_queue_pkg.sv | 47 ++++
 rtl/axi_req_queue_sync_fifo.sv | 54 +++++
 rtl/axi_req_queue.sv | 136 +++++++++++++
 3 files changed

// File: rtl/axi_req_queue_pkg.sv
// Shared encodings for the AXI request queue: master bus codes, response codes,
// access sizes, FSM states and the alignment/size-mask helpers.
package axi_req_queue_pkg;

  localparam logic [1:0] RW_NOP   = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;

  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_AXI    = 2'd1;
  localparam logic [1:0] ERR_DECERR = 2'd2;
  localparam logic [1:0] ERR_ALIGN  = 2'd3;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  // Only the low three address bits can make a legal size misaligned.
  function automatic logic misaligned(input logic [2:0] size, input logic [2:0] addr_lo);
    case (size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = addr_lo[0] != 1'b0;
      SIZE_W:  misaligned = addr_lo[1:0] != 2'b0;
      SIZE_D:  misaligned = addr_lo != 3'b0;
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [2:0] size);
    case (size)
      SIZE_B:  size_mask = 64'h0000_0000_0000_00FF;
      SIZE_H:  size_mask = 64'h0000_0000_0000_FFFF;
      SIZE_W:  size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/axi_req_queue_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags; a push while full is
// dropped regardless of a concurrent pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt, cnt_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_comb begin
    cnt_nxt = cnt;
    if (do_push && !do_pop)      cnt_nxt = cnt + (AW+1)'(1);
    else if (!do_push && do_pop) cnt_nxt = cnt - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt   <= cnt_nxt;
      full  <= cnt_nxt == (AW+1)'(DEPTH);
      empty <= cnt_nxt == '0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/axi_req_queue.sv
// Buffers core load/store requests, issues them one at a time to
// simple_axi_master and returns tagged responses in order.
module axi_req_queue
  import axi_req_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_write,
  input  logic [31:0]      i_req_addr,
  input  logic [63:0]      i_req_wdata,
  input  logic [2:0]       i_req_size,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [63:0]      o_rsp_rdata,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic [1:0]       o_rsp_err,
  output logic [31:0]      o_m_addr,
  output logic [63:0]      o_m_wdata,
  output logic [2:0]       o_m_wsize,
  output logic [1:0]       o_m_rw,
  output logic             o_m_clear_done,
  input  logic [63:0]      i_m_rdata,
  input  logic             i_m_wait,
  input  logic             i_m_done,
  input  logic             i_m_invalid,
  input  logic             i_m_error
);

  localparam int REQ_W = 1 + 32 + 64 + 3 + TAG_W;

  state_t             state, state_nxt;
  logic [REQ_W-1:0]   fifo_rdata;
  logic               fifo_full, fifo_empty, pop;
  logic               h_write, h_bad, wr_q;
  logic [31:0]        h_addr;
  logic [63:0]        h_wdata;
  logic [2:0]         h_size;
  logic [TAG_W-1:0]   h_tag;

  // The FSM already knows when the master is busy, so its wait flag is redundant.
  logic unused_m_wait;
  assign unused_m_wait = i_m_wait;

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (i_req_valid),
    .wdata ({i_req_write, i_req_addr, i_req_wdata, i_req_size, i_req_tag}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {h_write, h_addr, h_wdata, h_size, h_tag} = fifo_rdata;
  assign h_bad       = misaligned(h_size, h_addr[2:0]);
  assign o_req_ready = !fifo_full;

  always_comb begin
    state_nxt      = state;
    pop            = 1'b0;
    o_m_rw         = RW_NOP;
    o_m_clear_done = 1'b0;
    o_rsp_valid    = 1'b0;
    case (state)
      S_IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = h_bad ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        o_m_rw    = wr_q ? RW_WRITE : RW_READ;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (i_m_done) state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        o_m_clear_done = 1'b1;
        state_nxt      = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Rejected requests leave the master bus registers untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q        <= 1'b0;
      o_rsp_tag   <= '0;
      o_rsp_err   <= ERR_OK;
      o_rsp_rdata <= '0;
      o_m_addr    <= '0;
      o_m_wdata   <= '0;
      o_m_wsize   <= '0;
    end else begin
      case (state)
        S_IDLE: if (!fifo_empty) begin
          wr_q        <= h_write;
          o_rsp_tag   <= h_tag;
          o_rsp_rdata <= '0;
          if (h_bad) begin
            o_rsp_err <= ERR_ALIGN;
          end else begin
            o_rsp_err <= ERR_OK;
            o_m_addr  <= h_addr;
            o_m_wdata <= h_wdata;
            o_m_wsize <= h_size;
          end
        end
        // error/invalid are only meaningful in the first done cycle.
        S_WAIT: if (i_m_done) begin
          o_rsp_err <= i_m_invalid ? ERR_DECERR : (i_m_error ? ERR_AXI : ERR_OK);
        end
        S_CAPTURE: begin
          o_rsp_rdata <= (wr_q || o_rsp_err != ERR_OK) ? 64'd0
                                                       : (i_m_rdata & size_mask(o_m_wsize));
        end
        default: ;
      endcase
    end
  end

endmodule
